dma_copy_engine: RTL and testbench

- Data-mover core driven by the CSR block: latches SRC_ADDR/DST_ADDR/LEN on a start pulse and copies LEN bytes one 32-bit word at a time.
- Each word is a single-beat read followed by a single-beat write on an AXI4-Lite-style memory master.
- Returns busy, done pulse, error code and a byte-progress counter, which the CSR block maps into STATUS and IRQ_STATUS.

---
 rtl/dma_copy_engine.sv | 140 ++++++++++++++
 tb/tb_dma_copy_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-at-a-time memory copy over an AXI4-Lite-style master.
// Ports:
//   start/src_addr/dst_addr/len   transfer request, latched when idle
//   busy/done/err/err_code        status; err/err_code stick until the next accepted start
//   bytes_done                    bytes written back with an OKAY B response
//   m_ar*/m_r*                    single-beat read channel
//   m_aw*/m_w*/m_b*               single-beat write channel
`timescale 1ns/1ps
module dma_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [LEN_W-1:0]  bytes_done,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CHECK   = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_DATA = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;
    localparam logic [2:0] FINISH  = 3'd6;

    logic [2:0]        state;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  rem;
    logic [DATA_W-1:0] word_buf;
    logic              aw_done, w_done;
    logic              aw_ok, w_ok;

    // A channel counts as complete if it finished earlier or handshakes this cycle
    assign aw_ok = aw_done | m_awready;
    assign w_ok  = w_done | m_wready;

    assign busy      = state inside {CHECK, RD_ADDR, RD_DATA, WR, WR_RESP};
    assign done      = state == FINISH;
    assign m_araddr  = src;
    assign m_arvalid = state == RD_ADDR;
    assign m_rready  = state == RD_DATA;
    assign m_awaddr  = dst;
    assign m_awvalid = state == WR && !aw_done;
    assign m_wdata   = word_buf;
    assign m_wstrb   = state == WR ? 4'hF : 4'h0;
    assign m_wvalid  = state == WR && !w_done;
    assign m_bready  = state == WR_RESP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            rem        <= '0;
            word_buf   <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            bytes_done <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src        <= src_addr;
                    dst        <= dst_addr;
                    rem        <= len;
                    err        <= 1'b0;
                    err_code   <= 2'd0;
                    bytes_done <= '0;
                    state      <= CHECK;
                end
                CHECK: if (|{src[1:0], dst[1:0], rem[1:0]}) begin
                    err      <= 1'b1;
                    err_code <= 2'd1;
                    state    <= FINISH;
                end else begin
                    state <= rem == '0 ? FINISH : RD_ADDR;
                end
                RD_ADDR: if (m_arready) state <= RD_DATA;
                RD_DATA: if (m_rvalid) begin
                    if (m_rresp == 2'b00) begin
                        word_buf <= m_rdata;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        state    <= WR;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                        state    <= FINISH;
                    end
                end
                WR: begin
                    aw_done <= aw_ok;
                    w_done  <= w_ok;
                    if (aw_ok && w_ok) state <= WR_RESP;
                end
                WR_RESP: if (m_bvalid) begin
                    if (m_bresp == 2'b00) begin
                        bytes_done <= bytes_done + LEN_W'(4);
                        src        <= src + ADDR_W'(4);
                        dst        <= dst + ADDR_W'(4);
                        rem        <= rem - LEN_W'(4);
                        state      <= rem == LEN_W'(4) ? FINISH : RD_ADDR;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        state    <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: randomized scoreboard bench for dma_copy_engine with a behavioural memory slave.
`timescale 1ns/1ps
module tb_dma_copy_engine;
    logic        clk, rst_n, start;
    logic [31:0] src_addr, dst_addr, len;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] bytes_done;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    dma_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .bytes_done(bytes_done),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
    typedef struct packed {logic e; logic [1:0] c; logic [31:0] b;} dn_t;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    dn_t         exp_dn[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];

    int n_vec = 0, n_err = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, first_ar_cyc = -1, start_cyc = 0;
    int rd_err = -1, wr_err = -1, max_wait = 0, r_wait0 = -1, rd_cnt = 0, wr_cnt = 0;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
    logic [31:0] r_addr, wa, wd;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got activity expected none", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
    endfunction
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] srd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic int rnd();
        return int'($urandom_range(0, max_wait));
    endfunction

    // Reference: copy proceeds word by word in ascending order, stopping at the first error
    function automatic void model(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                                  input int rde, input int wre);
        dn_t e;
        wr_t w;
        e = '0;
        if (s[1:0] != 0 || d[1:0] != 0 || l[1:0] != 0) begin
            e.e = 1;
            e.c = 1;
        end else begin
            for (int i = 0; i < int'(l / 4); i++) begin
                exp_rd.push_back(s + 32'(4 * i));
                if (i == rde) begin
                    e.e = 1;
                    e.c = 2;
                    break;
                end
                w.a = d + 32'(4 * i);
                w.d = mrd(s + 32'(4 * i));
                exp_wr.push_back(w);
                if (i == wre) begin
                    e.e = 1;
                    e.c = 3;
                    break;
                end
                model_mem[w.a] = w.d;
                e.b += 4;
            end
        end
        exp_dn.push_back(e);
    endfunction

    // Memory slave: decides ready/valid at each falling edge from the DUT's settled outputs
    initial begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        forever begin
            @(negedge clk);
            m_arready = 0; m_rvalid = 0; m_rresp = 0;
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
            if (!rst_n) begin
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
            end else begin
                if (r_pend) begin
                    if (r_wait > 0) r_wait--;
                    else begin
                        m_rvalid = 1;
                        m_rdata = srd(r_addr);
                        m_rresp = rd_cnt == rd_err ? 2'b11 : 2'b00;
                        if (m_rready) begin
                            r_pend = 0;
                            rd_cnt++;
                        end
                    end
                end
                if (m_arvalid && !r_pend) begin
                    if (ar_wait > 0) ar_wait--;
                    else begin
                        m_arready = 1;
                        r_addr = m_araddr;
                        r_pend = 1;
                        r_wait = (rd_cnt == 0 && r_wait0 >= 0) ? r_wait0 : rnd();
                        ar_wait = rnd();
                    end
                end
                if (b_pend) begin
                    if (b_wait > 0) b_wait--;
                    else begin
                        m_bvalid = 1;
                        m_bresp = wr_cnt == wr_err ? 2'b10 : 2'b00;
                        if (m_bready) begin
                            if (m_bresp == 2'b00) mem[wa] = wd;
                            b_pend = 0; aw_got = 0; w_got = 0;
                            wr_cnt++;
                            aw_wait = rnd();
                            w_wait = rnd();
                        end
                    end
                end
                if (m_awvalid && !aw_got) begin
                    if (aw_wait > 0) aw_wait--;
                    else begin
                        m_awready = 1;
                        wa = m_awaddr;
                        aw_got = 1;
                    end
                end
                if (m_wvalid && !w_got) begin
                    if (w_wait > 0) w_wait--;
                    else begin
                        m_wready = 1;
                        wd = m_wdata;
                        w_got = 1;
                    end
                end
                if (aw_got && w_got && !b_pend) begin
                    b_pend = 1;
                    b_wait = rnd();
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake or signals done
    initial begin
        bit aw_seen = 0, w_seen = 0;
        int out_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                aw_seen = 0; w_seen = 0; out_cnt = 0;
            end else begin
                if (m_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
                if (m_arvalid && m_arready) begin
                    chk("rd_outstanding", 64'(out_cnt), 0);
                    out_cnt++;
                    if (exp_rd.size() == 0) miss("rd_unexpected");
                    else chk("rd_addr", m_araddr, exp_rd.pop_front());
                end
                if (m_rvalid && m_rready && m_rresp != 0) out_cnt--;
                if ((m_awvalid && m_awready) || (m_wvalid && m_wready)) begin
                    if (exp_wr.size() == 0) miss("wr_unexpected");
                    else begin
                        if (m_awvalid && m_awready) begin
                            chk("wr_addr", m_awaddr, exp_wr[0].a);
                            aw_seen = 1;
                        end
                        if (m_wvalid && m_wready) begin
                            chk("wr_data", {m_wstrb, m_wdata}, {4'hF, exp_wr[0].d});
                            w_seen = 1;
                        end
                        if (aw_seen && w_seen) begin
                            void'(exp_wr.pop_front());
                            aw_seen = 0;
                            w_seen = 0;
                        end
                    end
                end
                if (m_bvalid && m_bready) out_cnt--;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_busy", busy, 0);
                    if (exp_dn.size() == 0) miss("done_unexpected");
                    else chk("done_status", {err, err_code, bytes_done}, exp_dn.pop_front());
                end
            end
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {busy, done, err, err_code, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wstrb, m_bready}, 0);
        chk({name, "_bytes"}, bytes_done, 0);
        chk({name, "_addr"}, {m_araddr, m_awaddr}, 0);
        chk({name, "_wdata"}, m_wdata, 0);
    endtask

    task automatic setup(input int rde, input int wre, input int mw, input int aw0, input int w0, input int r0);
        rd_err = rde; wr_err = wre; max_wait = mw; r_wait0 = r0;
        ar_wait = 0; aw_wait = aw0; w_wait = w0; rd_cnt = 0; wr_cnt = 0;
        first_ar_cyc = -1;
    endtask

    task automatic pulse(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        @(negedge clk);
        start = 1; src_addr = s; dst_addr = d; len = l;
        start_cyc = cyc;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                       input int rde, input int wre, input int mw, input int aw0, input int w0,
                       input int r0, input bit restart);
        int d0;
        bit rs;
        setup(rde, wre, mw, aw0, w0, r0);
        model(s, d, l, rde, wre);
        d0 = done_cnt;
        rs = 0;
        pulse(s, d, l);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            @(negedge clk);
            if (restart && !rs && m_rready) begin
                start = 1; src_addr = 32'h9000_0000; dst_addr = 32'h9100_0000; len = 32'd64;
                rs = 1;
            end else start = 0;
        end
        start = 0;
        if (done_cnt == d0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done expected done");
        end
        repeat (4) @(negedge clk);
        chk("done_once", 64'(done_cnt - d0), 1);
        chk("queues_drained", {32'(exp_rd.size()), 16'(exp_wr.size()), 16'(exp_dn.size())}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [31:0] s, d, l;
        rst_n = 0; start = 0; src_addr = 0; dst_addr = 0; len = 0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4; i++) begin
            mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
            model_mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        run(32'h1000, 32'h2000, 16, -1, -1, 0, 0, 0, -1, 0);
        chk("basic_ar_latency", 64'(first_ar_cyc - start_cyc), 2);
        chk("basic_duration", 64'(done_cyc - start_cyc), 18);
        chk("basic_mem", {srd(32'h2000), srd(32'h2004), srd(32'h2008), srd(32'h200C)},
            {32'hA0, 32'hA1, 32'hA2, 32'hA3});

        run(32'h1000, 32'h2100, 0, -1, -1, 0, 0, 0, -1, 0);
        chk("zero_len_latency", 64'(done_cyc - start_cyc), 2);
        chk("zero_len_no_ar", 64'(first_ar_cyc), -1);

        run(32'h1002, 32'h2200, 8, -1, -1, 0, 0, 0, -1, 0);
        chk("misaligned_no_ar", 64'(first_ar_cyc), -1);

        run(32'h3000, 32'h3800, 12, -1, 1, 0, 0, 3, -1, 0);
        chk("wr_err_word0", mem.exists(32'h3800) ? mem[32'h3800] : 32'hX, init_word(32'h3000));
        chk("wr_err_word1_absent", 64'(mem.exists(32'h3804)), 0);
        chk("err_sticky", {err, err_code}, 3'b111);

        run(32'h4000, 32'h4800, 8, 0, -1, 0, 0, 0, 4, 1);

        setup(-1, -1, 1, 0, 0, -1);
        model(32'h5000, 32'h6000, 16, -1, -1);
        d0 = done_cnt;
        pulse(32'h5000, 32'h6000, 16);
        for (int i = 0; i < 100 && !(m_awvalid || m_wvalid); i++) @(negedge clk);
        chk("reached_wr", m_awvalid | m_wvalid, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        check_zero("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_no_done", 64'(done_cnt - d0), 0);
        exp_rd.delete(); exp_wr.delete(); exp_dn.delete();
        run(32'hFFFF_FFF8, 32'h7000, 16, -1, -1, 1, 0, 0, -1, 0);

        for (int t = 0; t < 24; t++) begin
            s = 32'h1_0000 + ($urandom_range(0, 255) << 2);
            d = 32'h8_0000 + ($urandom_range(0, 255) << 2);
            l = $urandom_range(0, 8) * 4;
            if ($urandom_range(0, 7) == 0) s[0] = 1'b1;
            if ($urandom_range(0, 7) == 0) l[1] = 1'b1;
            run(s, d, l,
                $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 3)) : -1,
                $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 3)) : -1,
                3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
